// File: rtl/pc_stack_unit.sv
// ---------------------------------------------------------------------------
// pc_stack_unit
// Program counter with clear / load / increment / call / return and an
// internal LIFO return-address stack. The PC value drives the instruction
// address; sticky flags report stack overflow and underflow.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear of PC, stack depth and flags
//   load        in   out <= in
//   inc         in   out <= out + STEP
//   call        in   push out + STEP, then out <= in
//   ret         in   out <= top of stack, then pop
//   in          in   load / call target address (WIDTH)
//   out         out  current PC (WIDTH, registered)
//   depth       out  occupied stack entries (registered)
//   stack_full  out  depth == DEPTH
//   stack_empty out  depth == 0
//   overflow    out  sticky: call issued while full
//   underflow   out  sticky: ret issued while empty
// Command priority per edge: clr > call > ret > load > inc > hold.
// ---------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned STEP  = 1,
    localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [DW-1:0]    depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] out_q, out_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [WIDTH-1:0] top_s;
    logic             full_s;
    logic             empty_s;
    logic [WIDTH-1:0] stack_q [DEPTH];

    assign full_s  = (depth_q == DW'(DEPTH));
    assign empty_s = (depth_q == {DW{1'b0}});
    // Return address wraps modulo 2^WIDTH like every other PC update.
    assign ret_addr_s = out_q + WIDTH'(STEP);

    // Select the top-of-stack entry (stack[depth-1]) as a plain mux.
    always_comb begin
        top_s = {WIDTH{1'b0}};
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_s = stack_q[i];
            end else begin
                top_s = top_s;
            end
        end
    end

    // Next-state decode with strict command priority; exactly one action.
    always_comb begin
        out_d   = out_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_s  = 1'b0;
        if (clr) begin
            out_d   = {WIDTH{1'b0}};
            depth_d = {DW{1'b0}};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (call) begin
            // The jump happens even when the push must be dropped.
            out_d = in;
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                push_s  = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end else if (ret) begin
            if (empty_s) begin
                unf_d = 1'b1;
            end else begin
                out_d   = top_s;
                depth_d = depth_q - DW'(1);
            end
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d = out_q + WIDTH'(STEP);
        end else begin
            out_d = out_q;
        end
    end

    // PC, depth and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= {WIDTH{1'b0}};
            depth_q <= {DW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; a pop only moves depth, so only pushes write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (push_s && (depth_q == DW'(i))) begin
                    stack_q[i] <= ret_addr_s;
                end else begin
                    stack_q[i] <= stack_q[i];
                end
            end
        end
    end

    assign out         = out_q;
    assign depth       = depth_q;
    assign stack_full  = full_s;
    assign stack_empty = empty_s;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_stack_unit
// Directed testbench: one instance with DEPTH = 8 (u8) and one with
// DEPTH = 2 (u2), both WIDTH = 16, STEP = 1, driven by shared inputs.
// ---------------------------------------------------------------------------
module tb_pc_stack_unit;

    logic        clk;
    logic        rst_n;
    logic        clr, load, inc, call, ret;
    logic [15:0] in_s;

    logic [15:0] out8, out2;
    logic [3:0]  depth8;
    logic [1:0]  depth2;
    logic        full8, empty8, ovf8, unf8;
    logic        full2, empty2, ovf2, unf2;

    int errors = 0;
    int checks = 0;

    pc_stack_unit #(.WIDTH(16), .DEPTH(8), .STEP(1)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc),
        .call(call), .ret(ret), .in(in_s), .out(out8), .depth(depth8),
        .stack_full(full8), .stack_empty(empty8),
        .overflow(ovf8), .underflow(unf8)
    );

    pc_stack_unit #(.WIDTH(16), .DEPTH(2), .STEP(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .inc(inc),
        .call(call), .ret(ret), .in(in_s), .out(out2), .depth(depth2),
        .stack_full(full2), .stack_empty(empty2),
        .overflow(ovf2), .underflow(unf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one command for one rising edge, then sample 1 time unit later.
    task automatic drive(input logic c_clr, input logic c_call, input logic c_ret,
                         input logic c_load, input logic c_inc, input logic [15:0] d);
        clr = c_clr; call = c_call; ret = c_ret; load = c_load; inc = c_inc; in_s = d;
        @(posedge clk);
        #1;
        clr = 1'b0; call = 1'b0; ret = 1'b0; load = 1'b0; inc = 1'b0;
    endtask

    task automatic test_reset();
        if (out8 !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out8); end checks++;
        if (depth8 !== 4'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", depth8); end checks++;
        if ({empty8, full8, ovf8, unf8} !== 4'b1000) begin errors++; $display("FAIL reset_status got=%b exp=1000", {empty8, full8, ovf8, unf8}); end checks++;
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        if (out8 !== 16'h0005) begin errors++; $display("FAIL inc_to_5 got=%h exp=0005", out8); end checks++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0050);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        // u8 now has out=0x0006 and underflow set; reset asynchronously mid-cycle.
        if (unf8 !== 1'b1) begin errors++; $display("FAIL pre_reset_unf got=%b exp=1", unf8); end checks++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0070);
        #2; rst_n = 1'b0; #1;
        if (out8 !== 16'h0000 || depth8 !== 4'd0) begin errors++; $display("FAIL async_reset got out=%h depth=%0d exp out=0000 depth=0", out8, depth8); end checks++;
        if ({ovf8, unf8, empty8} !== 3'b001) begin errors++; $display("FAIL async_reset_flags got=%b exp=001", {ovf8, unf8, empty8}); end checks++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_priority_wrap();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        if (out8 !== 16'hFFFF) begin errors++; $display("FAIL load_ffff got=%h exp=ffff", out8); end checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        if (out8 !== 16'h0000) begin errors++; $display("FAIL inc_wrap got=%h exp=0000", out8); end checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
        if (out8 !== 16'h1234) begin errors++; $display("FAIL load_over_inc got=%h exp=1234", out8); end checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h9999);
        if (out8 !== 16'h1234) begin errors++; $display("FAIL hold got=%h exp=1234", out8); end checks++;
    endtask

    task automatic test_nested();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0200);
        if (out8 !== 16'h0200 || depth8 !== 4'd2) begin errors++; $display("FAIL nested_calls got out=%h depth=%0d exp out=0200 depth=2", out8, depth8); end checks++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out8 !== 16'h0101) begin errors++; $display("FAIL ret1 got=%h exp=0101", out8); end checks++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out8 !== 16'h0011 || depth8 !== 4'd0 || empty8 !== 1'b1) begin errors++; $display("FAIL ret2 got out=%h depth=%0d empty=%b exp out=0011 depth=0 empty=1", out8, depth8, empty8); end checks++;
        // call+ret together acts as call
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300);
        if (out8 !== 16'h0300 || depth8 !== 4'd1) begin errors++; $display("FAIL call_over_ret got out=%h depth=%0d exp out=0300 depth=1", out8, depth8); end checks++;
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020);
        if (full2 !== 1'b1 || ovf2 !== 1'b0) begin errors++; $display("FAIL full_no_ovf got full=%b ovf=%b exp full=1 ovf=0", full2, ovf2); end checks++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0030);
        if (out2 !== 16'h0030 || depth2 !== 2'd2 || ovf2 !== 1'b1) begin errors++; $display("FAIL overflow got out=%h depth=%0d ovf=%b exp out=0030 depth=2 ovf=1", out2, depth2, ovf2); end checks++;
        // The dropped push leaves the stack holding 0x0001 and 0x0011.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out2 !== 16'h0011) begin errors++; $display("FAIL ovf_ret1 got=%h exp=0011", out2); end checks++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out2 !== 16'h0001 || empty2 !== 1'b1) begin errors++; $display("FAIL ovf_ret2 got out=%h empty=%b exp out=0001 empty=1", out2, empty2); end checks++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out2 !== 16'h0001 || depth2 !== 2'd0 || unf2 !== 1'b1) begin errors++; $display("FAIL underflow got out=%h depth=%0d unf=%b exp out=0001 depth=0 unf=1", out2, depth2, unf2); end checks++;
    endtask

    task automatic test_sticky_clr();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        if (out2 !== 16'h0002 || ovf2 !== 1'b1 || unf2 !== 1'b1) begin errors++; $display("FAIL sticky got out=%h ovf=%b unf=%b exp out=0002 ovf=1 unf=1", out2, ovf2, unf2); end checks++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0044);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0077);
        if (out2 !== 16'h0000 || depth2 !== 2'd0 || ovf2 !== 1'b0 || unf2 !== 1'b0) begin errors++; $display("FAIL clr_over_call got out=%h depth=%0d ovf=%b unf=%b exp 0000 0 0 0", out2, depth2, ovf2, unf2); end checks++;
    endtask

    task automatic test_ret_wrap();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
        if (out8 !== 16'h0040 || depth8 !== 4'd1) begin errors++; $display("FAIL wrap_call got out=%h depth=%0d exp out=0040 depth=1", out8, depth8); end checks++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out8 !== 16'h0000 || empty8 !== 1'b1) begin errors++; $display("FAIL wrap_ret got out=%h empty=%b exp out=0000 empty=1", out8, empty8); end checks++;
    endtask

    task automatic test_fill_depth8();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'(16'h1000 + 16'(i) * 16'h0100));
        if (depth8 !== 4'd8 || full8 !== 1'b1 || ovf8 !== 1'b0) begin errors++; $display("FAIL fill8 got depth=%0d full=%b ovf=%b exp 8 1 0", depth8, full8, ovf8); end checks++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        if (out8 !== 16'h1601 || depth8 !== 4'd7) begin errors++; $display("FAIL fill8_ret got out=%h depth=%0d exp out=1601 depth=7", out8, depth8); end checks++;
    endtask

    initial begin
        rst_n = 1'b0;
        clr = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0; in_s = 16'h0000;
        #3;
        test_reset();
        test_priority_wrap();
        test_nested();
        test_overflow();
        test_sticky_clr();
        test_ret_wrap();
        test_fill_depth8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
